// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/halt sequencer:
// state encoding, state width and the default halt instruction word.
package cpu_ctrl_pkg;

  localparam int CTRL_STATE_W = 2;
  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HALT  = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/cpu_cycle_counter.sv
// Enabled-cycle counter with clear and saturation. Also provides a registered
// flag that is high while the count sits one below the watchdog limit.
module cpu_cycle_counter #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(MAX_CYCLES - 1);
  localparam bit               WD_EN   = (MAX_CYCLES != 0);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tc;
  logic [CNT_W-1:0] w_cnt_nx;

  always_comb begin
    w_cnt_nx = r_cnt;
    if (clr_i)
      w_cnt_nx = '0;
    else if (inc_i && (r_cnt != CNT_SAT))
      w_cnt_nx = r_cnt + CNT_W'(1);
  end

  // Compare the next value so the flag lines up with the count it describes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_tc  <= WD_EN && (w_cnt_nx == TC_VAL);
    end
  end

  assign cnt_o = r_cnt;
  assign tc_o  = r_tc;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for Simple_Single_CPU: holds the CPU in reset until
// started, gates execution per cycle, stops on the halt word or the watchdog.
//
// state    | meaning
// ST_IDLE  | CPU held in reset, counters and snapshots cleared
// ST_RUN   | executing one instruction per cycle
// ST_PAUSE | frozen; a step request executes exactly one instruction
// ST_HALT  | program ended (halt word or watchdog), snapshot held
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter int          MAX_CYCLES = 200,
  parameter int          CNT_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    step_i,
  input  logic [31:0]             instr_i,
  input  logic [31:0]             pc_i,
  output logic                    cpu_rst_o,
  output logic                    cpu_en_o,
  output logic [CTRL_STATE_W-1:0] state_o,
  output logic                    halted_o,
  output logic                    timeout_o,
  output logic                    done_o,
  output logic [31:0]             halt_pc_o,
  output logic [CNT_W-1:0]        cycle_cnt_o
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nx;
  logic        r_step_q;
  logic        r_restart_q;
  logic        r_timeout;
  logic        r_done;
  logic [31:0] r_halt_pc;

  logic        w_is_halt;
  logic        w_en;
  logic        w_tc;
  logic        w_step_nx;
  logic        w_restart_nx;
  logic        w_capture;
  logic        w_wd_fire;

  assign w_is_halt = (instr_i == HALT_INSTR);
  // The halt word is never executed, so the PC stays parked on its address.
  assign w_en = ((r_state == ST_RUN) || ((r_state == ST_PAUSE) && r_step_q)) && !w_is_halt;

  cpu_cycle_counter #(
    .CNT_W     (CNT_W),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(r_state == ST_IDLE),
    .inc_i(w_en),
    .cnt_o(cycle_cnt_o),
    .tc_o (w_tc)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_step_nx    = 1'b0;
    w_restart_nx = 1'b0;
    w_capture    = 1'b0;
    w_wd_fire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i || r_restart_q) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (w_is_halt) begin
          w_state_nx = ST_HALT;
          w_capture  = 1'b1;
        end else if (w_tc) begin
          w_state_nx = ST_HALT;
          w_capture  = 1'b1;
          w_wd_fire  = 1'b1;
        end else if (stop_i) begin
          w_state_nx = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (r_step_q && w_is_halt) begin
          w_state_nx = ST_HALT;
          w_capture  = 1'b1;
        end else if (r_step_q && w_tc) begin
          w_state_nx = ST_HALT;
          w_capture  = 1'b1;
          w_wd_fire  = 1'b1;
        end else if (start_i) begin
          w_state_nx = ST_RUN;
        end else if (step_i && !r_step_q) begin
          w_step_nx = 1'b1;
        end
      end
      ST_HALT: begin
        if (start_i) begin
          w_state_nx   = ST_IDLE;
          w_restart_nx = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_step_q    <= 1'b0;
      r_restart_q <= 1'b0;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
      r_halt_pc   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_step_q    <= w_step_nx;
      r_restart_q <= w_restart_nx;
      r_done      <= (w_state_nx == ST_HALT) && (r_state != ST_HALT);
      if (r_state == ST_IDLE) begin
        r_timeout <= 1'b0;
        r_halt_pc <= '0;
      end else begin
        if (w_capture) r_halt_pc <= pc_i;
        if (w_wd_fire) r_timeout <= 1'b1;
      end
    end
  end

  assign cpu_rst_o = (r_state == ST_IDLE);
  assign cpu_en_o  = w_en;
  assign state_o   = r_state;
  assign halted_o  = (r_state == ST_HALT);
  assign timeout_o = r_timeout;
  assign done_o    = r_done;
  assign halt_pc_o = r_halt_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: emulates PC + instruction memory and checks every
// cycle against a behavioural model, plus directed scenario checks.
module tb_cpu_run_ctrl;

  localparam int          MAXC  = 200;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, step_i = 1'b0;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic        cpu_rst_o, cpu_en_o, halted_o, timeout_o, done_o;
  logic [1:0]  state_o;
  logic [31:0] halt_pc_o;
  logic [15:0] cycle_cnt_o;

  cpu_run_ctrl #(.HALT_INSTR(HALTW), .MAX_CYCLES(MAXC), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .step_i(step_i),
    .instr_i(instr_i), .pc_i(pc_i), .cpu_rst_o(cpu_rst_o), .cpu_en_o(cpu_en_o),
    .state_o(state_o), .halted_o(halted_o), .timeout_o(timeout_o), .done_o(done_o),
    .halt_pc_o(halt_pc_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: mode uses the published state codes (0 idle, 1 run, 2 pause, 3 halt).
  int          m_mode;
  bit          m_step, m_restart, m_timeout, m_done;
  int unsigned m_cnt;
  logic [31:0] m_hpc;
  logic [31:0] pc;
  bit          loop_mode;
  logic [31:0] imem [64];
  int          n_en, n_done, n_rst;

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_restart = 0; m_timeout = 0; m_done = 0;
    m_cnt = 0; m_hpc = '0; pc = '0;
  endtask

  task automatic fill_imem(input int halt_odds);
    for (int i = 0; i < 64; i++)
      imem[i] = (halt_odds != 0 && $urandom_range(0, halt_odds - 1) == 0) ? HALTW
                : ($urandom() & 32'hFFFF_FFFE);
  endtask

  // Called right after a posedge (or at time 0); asserts reset mid-cycle.
  task automatic apply_reset(input int edges);
    #2;
    rst_i = 1'b1; start_i = 0; stop_i = 0; step_i = 0;
    #1;
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_cpu_en", 32'(cpu_en_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_cnt", 32'(cycle_cnt_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_halt_pc", halt_pc_o, 32'd0);
    model_reset();
    repeat (edges) @(posedge clk);
    #2 rst_i = 1'b0;
  endtask

  task automatic cyc(input bit st, input bit sp, input bit stp, input bit fh);
    bit ih, ex, wd, ns, nr, nt, nd;
    int nm;
    int unsigned nc;
    logic [31:0] nh;
    @(negedge clk);
    start_i = st; stop_i = sp; step_i = stp;
    pc_i = pc;
    instr_i = fh ? HALTW : imem[pc[7:2]];
    #1;
    ih = (instr_i == HALTW);
    ex = ((m_mode == 1) || (m_mode == 2 && m_step)) && !ih;
    check("cpu_en", 32'(cpu_en_o), 32'(ex));
    check("cpu_rst", 32'(cpu_rst_o), 32'(m_mode == 0));
    check("state", 32'(state_o), 32'(m_mode));
    check("halted", 32'(halted_o), 32'(m_mode == 3));
    check("timeout", 32'(timeout_o), 32'(m_timeout));
    check("done", 32'(done_o), 32'(m_done));
    check("halt_pc", halt_pc_o, m_hpc);
    check("cycle_cnt", 32'(cycle_cnt_o), m_cnt);
    if (ex) n_en++;
    if (m_done) n_done++;
    if (m_mode == 0) n_rst++;
    nm = m_mode; ns = 0; nr = 0; nt = m_timeout; nh = m_hpc; nc = m_cnt;
    wd = (m_cnt == MAXC - 1);
    if (ex && m_cnt != 65535) nc = m_cnt + 1;
    case (m_mode)
      0: begin
        if (st || m_restart) nm = 1;
        nc = 0; nt = 0; nh = '0;
      end
      1: begin
        if (ih) begin nm = 3; nh = pc_i; end
        else if (wd) begin nm = 3; nt = 1; nh = pc_i; end
        else if (sp) nm = 2;
      end
      2: begin
        if (m_step && ih) begin nm = 3; nh = pc_i; end
        else if (m_step && wd) begin nm = 3; nt = 1; nh = pc_i; end
        else if (st) nm = 1;
        else if (stp && !m_step) ns = 1;
      end
      default: begin
        if (st) begin nm = 0; nr = 1; end
      end
    endcase
    nd = (nm == 3) && (m_mode != 3);
    @(posedge clk);
    if (m_mode == 0) pc = '0;
    else if (ex && !loop_mode) pc = pc + 32'd4;
    m_mode = nm; m_step = ns; m_restart = nr; m_timeout = nt;
    m_hpc = nh; m_cnt = nc; m_done = nd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    model_reset();
    loop_mode = 0;
    fill_imem(0);
    apply_reset(2);

    // Straight-line program, halt word at PC 0x40.
    imem[16] = HALTW;
    n_en = 0; n_done = 0;
    cyc(1, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    #1;
    check("sl_en_cycles", 32'(n_en), 32'd16);
    check("sl_done_pulses", 32'(n_done), 32'd1);
    check("sl_halt_pc", halt_pc_o, 32'h40);
    check("sl_cnt", 32'(cycle_cnt_o), 32'd16);
    check("sl_halted", 32'(halted_o), 32'd1);
    check("sl_timeout", 32'(timeout_o), 32'd0);

    // Restart from HALT.
    n_rst = 0;
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    #1;
    check("rs_rst_cycles", 32'(n_rst), 32'd1);
    check("rs_halt_pc", halt_pc_o, 32'd0);
    check("rs_halted", 32'(halted_o), 32'd0);
    check("rs_cnt", 32'(cycle_cnt_o), 32'd2);

    // Watchdog on a branch-to-self loop.
    apply_reset(1);
    loop_mode = 1; n_en = 0;
    cyc(1, 0, 0, 0);
    repeat (205) cyc(0, 0, 0, 0);
    #1;
    check("wd_en_cycles", 32'(n_en), 32'd200);
    check("wd_timeout", 32'(timeout_o), 32'd1);
    check("wd_cnt", 32'(cycle_cnt_o), 32'd200);
    check("wd_en_after", 32'(cpu_en_o), 32'd0);

    // Pause and single-step.
    apply_reset(1);
    loop_mode = 0;
    fill_imem(0);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    n_en = 0;
    cyc(0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0);
      repeat (2) cyc(0, 0, 0, 0);
    end
    #1;
    check("ps_en_cycles", 32'(n_en), 32'd4);
    check("ps_cnt", 32'(cycle_cnt_o), 32'd8);
    check("ps_state", 32'(state_o), 32'd2);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    #1;
    check("ps_resume_cnt", 32'(cycle_cnt_o), 32'd11);
    check("ps_resume_state", 32'(state_o), 32'd1);

    // Halt word together with stop.
    n_done = 0;
    cyc(0, 1, 0, 1);
    repeat (2) cyc(0, 0, 0, 0);
    #1;
    check("col_halt_stop_state", 32'(state_o), 32'd3);
    check("col_halt_stop_done", 32'(n_done), 32'd1);

    // start with stop while running.
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    #1;
    check("col_start_stop_state", 32'(state_o), 32'd2);

    // Halt word in the cycle the watchdog would expire.
    apply_reset(1);
    loop_mode = 1;
    cyc(1, 0, 0, 0);
    repeat (199) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    #1;
    check("col_halt_wd_timeout", 32'(timeout_o), 32'd0);
    check("col_halt_wd_state", 32'(state_o), 32'd3);
    check("col_halt_wd_cnt", 32'(cycle_cnt_o), 32'd199);

    // Asynchronous reset in RUN cycle 7.
    apply_reset(1);
    loop_mode = 0;
    cyc(1, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 0);
    apply_reset(1);

    // Randomized traffic against the model.
    fill_imem(25);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) apply_reset(1);
      else begin
        if ($urandom_range(0, 99) == 0) loop_mode = !loop_mode;
        cyc($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/halt sequencer for Simple_Single_CPU; sits between the top level and the CPU datapath.
- Holds the CPU in reset until started, then gates execution with a per-cycle enable.
- Detects the halt instruction (all-ones word) on the instruction-memory output and stops before executing it.
- Provides single-step debug, a watchdog cycle limit, and a final PC/cycle-count snapshot for the bench.

Parameters:
- HALT_INSTR, 32'hFFFFFFFF, instruction word that ends a program.
- MAX_CYCLES, 200, watchdog limit in enabled cycles; 0 disables the watchdog.
- CNT_W, 16, width of the cycle counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  start a program, or resume from PAUSE.
- stop_i  in  1  pause a running program.
- step_i  in  1  execute exactly one instruction while paused.
- instr_i  in  32  current instruction from IM.
- pc_i  in  32  current PC from the PC register.
- cpu_rst_o  out  1  reset to the CPU PC and register file, active-high.
- cpu_en_o  out  1  write enable for PC, register file and data memory.
- state_o  out  2  current state: IDLE=00, RUN=01, PAUSE=10, HALT=11.
- halted_o  out  1  high while in HALT.
- timeout_o  out  1  sticky; set when the watchdog ends the run.
- done_o  out  1  one-cycle pulse on entry to HALT.
- halt_pc_o  out  32  PC captured at halt or timeout.
- cycle_cnt_o  out  CNT_W  count of enabled (executed) cycles.

Behaviour:
- Reset (async, immediate) and reset values:
  - state IDLE; cpu_rst_o=1; cpu_en_o=0.
  - halted_o, timeout_o, done_o = 0; halt_pc_o=0; cycle_cnt_o=0; internal step_q and restart_q = 0.
- is_halt = (instr_i == HALT_INSTR).
- cpu_en_o is combinational: ((state==RUN) | (state==PAUSE & step_q)) & ~is_halt. The halt instruction is never executed, so the PC stays on its address.
- cpu_rst_o = (state==IDLE), decoded from the state register.
- IDLE:
  - start_i or restart_q -> RUN.
  - Clear cycle_cnt_o, timeout_o, halted_o and halt_pc_o.
- RUN, priority order (first match wins):
  - is_halt -> HALT; capture pc_i into halt_pc_o; cycle_cnt_o unchanged.
  - Watchdog: MAX_CYCLES!=0 and cycle_cnt_o==MAX_CYCLES-1 -> HALT; timeout_o=1; cycle_cnt_o becomes MAX_CYCLES; capture pc_i (after-edge PC not required).
  - stop_i -> PAUSE. The cycle in which stop_i is high still executes.
  - Otherwise stay in RUN; cycle_cnt_o += 1.
- start_i in RUN is ignored, including when asserted together with stop_i.
- PAUSE:
  - step_i sampled high -> step_q=1 for exactly the next cycle, giving a one-cycle cpu_en_o.
  - If is_halt during that step cycle -> HALT, no execution.
  - A step cycle that executes increments cycle_cnt_o and is subject to the watchdog.
  - start_i -> RUN without clearing counters; start_i wins over step_i when both are high.
  - step_i while step_q=1 is ignored.
- HALT:
  - cpu_en_o=0; halted_o=1.
  - done_o pulses on the first HALT cycle only.
  - start_i -> IDLE with restart_q=1: one IDLE cycle with cpu_rst_o=1, then RUN automatically.
  - stop_i and step_i are ignored.
- Counter:
  - With MAX_CYCLES=0 the counter saturates at all-ones.
  - MAX_CYCLES must be <= 2^CNT_W-1.
- Reset mid-operation aborts at once: cpu_rst_o rises before the next edge, and no pending step survives.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants (IDLE/RUN/PAUSE/HALT);
  - HALT_INSTR default;
  - the CTRL_STATE_W=2 constant.
- One sub-module, cpu_cycle_counter: enabled counter with clear, saturation, and a registered terminal-count compare against MAX_CYCLES.
- The FSM stays in cpu_run_ctrl.

Test Plan:
- Straight-line run: reset 2 cycles, start_i pulse, 16 instructions then HALT_INSTR at PC 0x40 -> cpu_en_o high 16 cycles, done_o single pulse, halted_o=1, halt_pc_o=0x40, cycle_cnt_o=16, timeout_o=0.
- Watchdog: branch-to-self loop, MAX_CYCLES=200 -> HALT after 200 enabled cycles, timeout_o=1, cycle_cnt_o=200, cpu_en_o=0 afterwards.
- Pause/step: stop_i in the 5th RUN cycle -> cpu_en_o high that cycle then low, state_o=10. Three step_i pulses -> three one-cycle cpu_en_o pulses, each one cycle after its step; cycle_cnt_o=8. Then start_i -> RUN resumes with no count reset.
- Collisions:
  - halt word and stop_i in the same cycle -> HALT with done_o.
  - halt word in the cycle the watchdog would expire -> HALT, timeout_o=0.
  - start_i with stop_i in RUN -> PAUSE.
- Async reset at RUN cycle 7, mid-cycle -> cpu_rst_o=1 and cpu_en_o=0 before the next edge; cycle_cnt_o=0; state_o=00.
- Restart: start_i while halted -> exactly one cycle with cpu_rst_o=1, then RUN with cycle_cnt_o=0, halted_o=0, halt_pc_o=0.
